// File: rtl/im_loader.sv
// im_loader: write side of the instruction memory.
// Receives a valid/ready byte stream framed as a 4-byte big-endian word count N
// followed by N big-endian data words. Each word goes to consecutive IM slots
// starting at index 0. cpu_hold keeps the CPU in reset until the image has been
// fully written.
// Optional feature macro: IM_LOADER_CSUM_EN. When it is defined, a trailing
// checksum word (the mod-2^32 sum of the data words) is received and verified
// before the load is declared done.
module im_loader #(
  parameter int IM_DEPTH = 1024,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              reload,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [2:0] S_LEN  = 3'd0;
  localparam logic [2:0] S_DATA = 3'd1;
`ifdef IM_LOADER_CSUM_EN
  localparam logic [2:0] S_CSUM = 3'd2;
`endif
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [ADDR_W:0] W_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [2:0]        state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       shift_q, shift_d;      // first three bytes of the current word
  logic [ADDR_W:0]   len_q, len_d;          // range-checked word count N
  logic [ADDR_W:0]   words_q, words_d;      // words written; also next write index
  logic              im_we_q, im_we_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [31:0]       im_wdata_q, im_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef IM_LOADER_CSUM_EN
  logic [31:0]       csum_q, csum_d;
`endif

  logic        accept;
  logic        last_byte;
  logic [31:0] word_full;

  // The loader only refuses bytes once the image is complete.
  always_comb begin
    rx_ready = (state_q != S_DONE);
  end

  // Byte packing, state transitions and the registered IM write request.
  always_comb begin
    accept     = rx_valid && rx_ready;
    last_byte  = accept && (byte_cnt_q == 2'd3);
    word_full  = {shift_q, rx_data};
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    len_d      = len_q;
    words_d    = words_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
`ifdef IM_LOADER_CSUM_EN
    csum_d     = csum_q;
`endif

    if (accept) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      shift_d    = {shift_q[15:0], rx_data};
    end

    case (state_q)
      S_LEN: begin
        if (last_byte) begin
          if (word_full > 32'(IM_DEPTH)) begin
            state_d = S_ERR;
          end else if (word_full == 32'd0) begin
`ifdef IM_LOADER_CSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end else begin
            len_d   = word_full[ADDR_W:0];
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (last_byte) begin
          im_we_d    = 1'b1;
          im_addr_d  = words_q[ADDR_W-1:0];
          im_wdata_d = word_full;
          words_d    = words_q + W_ONE;
`ifdef IM_LOADER_CSUM_EN
          csum_d     = csum_q + word_full;
`endif
          if ((words_q + W_ONE) == len_q) begin
`ifdef IM_LOADER_CSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end
        end
      end
`ifdef IM_LOADER_CSUM_EN
      S_CSUM: begin
        if (last_byte) begin
          state_d = (word_full == csum_q) ? S_DONE : S_ERR;
        end
      end
`endif
      S_DONE, S_ERR: begin
        // Bytes arriving in S_ERR are accepted above and simply never used.
        if (reload) begin
          state_d    = S_LEN;
          byte_cnt_d = 2'd0;
          shift_d    = 24'd0;
          len_d      = '0;
          words_d    = '0;
`ifdef IM_LOADER_CSUM_EN
          csum_d     = 32'd0;
`endif
        end
      end
      default: begin
        state_d = S_LEN;
      end
    endcase

    // Status lags the state by one cycle so the CPU is released only after
    // the final IM write has committed.
    done_d     = (state_q == S_DONE) && !reload;
    err_d      = (state_q == S_ERR) && !reload;
    cpu_hold_d = !done_d;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_LEN;
      byte_cnt_q <= 2'd0;
      shift_q    <= 24'd0;
      len_q      <= '0;
      words_q    <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= 32'd0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef IM_LOADER_CSUM_EN
      csum_q     <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      len_q      <= len_d;
      words_q    <= words_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef IM_LOADER_CSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Drive outputs straight from registers.
  always_comb begin
    im_we        = im_we_q;
    im_addr      = im_addr_q;
    im_wdata     = im_wdata_q;
    cpu_hold     = cpu_hold_q;
    load_done    = done_q;
    load_err     = err_q;
    words_loaded = words_q;
  end

endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: directed test of im_loader framing, write timing, error path,
// reload, mid-word reset and (when IM_LOADER_CSUM_EN is defined) checksum.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_ready;
  logic        reload = 1'b0;
  logic        im_we;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [10:0] words_loaded;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  always #5 clk = ~clk;

  im_loader #(.IM_DEPTH(1024), .ADDR_W(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .reload       (reload),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  // Log every IM write, sampled away from the active edge.
  always @(negedge clk) begin
    if (im_we) begin
      wr_addr_q.push_back(32'(im_addr));
      wr_data_q.push_back(im_wdata);
      $display("write idx=%0d data=0x%08h", im_addr, im_wdata);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic clk_n(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clk_n(2);
    reset = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit acc;
    acc = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk);
        #1;
        acc = 1'b1;
      end
    end
    rx_valid = 1'b0;
    if (!acc) check_eq("byte_accept_timeout", 32'(rx_ready), 32'd1);
    if (gap) clk_n(1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  // Sends a frame of up to two data words (plus the checksum when enabled).
  task automatic send_frame(input logic [31:0] n, input logic [31:0] w0,
                            input logic [31:0] w1, input bit gap);
    logic [31:0] sum;
    sum = 32'd0;
    send_word(n, gap);
    if (n > 0) begin send_word(w0, gap); sum = sum + w0; end
    if (n > 1) begin send_word(w1, gap); sum = sum + w1; end
`ifdef IM_LOADER_CSUM_EN
    send_word(sum, gap);
`endif
  endtask

  task automatic check_log(input string pfx, input int n,
                           input logic [31:0] d0, input logic [31:0] d1);
    check_eq({pfx, "_nwrites"}, 32'(wr_addr_q.size()), 32'(n));
    if (n > 0 && wr_addr_q.size() > 0) begin
      check_eq({pfx, "_addr0"}, wr_addr_q[0], 32'd0);
      check_eq({pfx, "_data0"}, wr_data_q[0], d0);
    end
    if (n > 1 && wr_addr_q.size() > 1) begin
      check_eq({pfx, "_addr1"}, wr_addr_q[1], 32'd1);
      check_eq({pfx, "_data1"}, wr_data_q[1], d1);
    end
  endtask

  // Final-state checks for the two-word test-1 image, called right after the
  // last frame byte has been accepted.
  task automatic check_test1(input string pfx);
`ifndef IM_LOADER_CSUM_EN
    check_eq({pfx, "_we_last"},    32'(im_we),    32'd1);
    check_eq({pfx, "_addr_last"},  32'(im_addr),  32'd1);
    check_eq({pfx, "_wdata_last"}, im_wdata,      32'h0000000C);
`endif
    check_eq({pfx, "_hold_edge"},  32'(cpu_hold),  32'd1);
    check_eq({pfx, "_done_edge"},  32'(load_done), 32'd0);
    clk_n(1);
    check_eq({pfx, "_hold"},   32'(cpu_hold),     32'd0);
    check_eq({pfx, "_done"},   32'(load_done),    32'd1);
    check_eq({pfx, "_err"},    32'(load_err),     32'd0);
    check_eq({pfx, "_ready"},  32'(rx_ready),     32'd0);
    check_eq({pfx, "_words"},  32'(words_loaded), 32'd2);
    check_log(pfx, 2, 32'h24080005, 32'h0000000C);
  endtask

  initial begin
    // Reset state
    do_reset();
    check_eq("rst_ready", 32'(rx_ready),     32'd1);
    check_eq("rst_hold",  32'(cpu_hold),     32'd1);
    check_eq("rst_done",  32'(load_done),    32'd0);
    check_eq("rst_err",   32'(load_err),     32'd0);
    check_eq("rst_we",    32'(im_we),        32'd0);
    check_eq("rst_addr",  32'(im_addr),      32'd0);
    check_eq("rst_words", 32'(words_loaded), 32'd0);

    // Test 1: two-word image, back-to-back bytes
    clear_log();
    send_frame(32'd2, 32'h24080005, 32'h0000000C, 1'b0);
    check_test1("t1");

    // Reload from DONE clears status and re-holds the CPU
    reload = 1'b1;
    clk_n(1);
    reload = 1'b0;
    check_eq("rl_done",  32'(load_done),    32'd0);
    check_eq("rl_hold",  32'(cpu_hold),     32'd1);
    check_eq("rl_words", 32'(words_loaded), 32'd0);
    check_eq("rl_ready", 32'(rx_ready),     32'd1);

    // Test 2: oversize length then reload with a valid one-word image
    do_reset();
    clear_log();
    send_word(32'h00000401, 1'b0);
    clk_n(1);
    check_eq("t2_err",   32'(load_err), 32'd1);
    check_eq("t2_hold",  32'(cpu_hold), 32'd1);
    check_eq("t2_ready", 32'(rx_ready), 32'd1);
    send_word(32'hAABBCCDD, 1'b0);
    clk_n(1);
    check_eq("t2_err_hold", 32'(load_err), 32'd1);
    check_log("t2_nowr", 0, 32'd0, 32'd0);
    reload = 1'b1;
    clk_n(1);
    reload = 1'b0;
    check_eq("t2_rl_err",  32'(load_err), 32'd0);
    check_eq("t2_rl_hold", 32'(cpu_hold), 32'd1);
    send_frame(32'd1, 32'hDEADBEEF, 32'd0, 1'b0);
    clk_n(1);
    check_eq("t2_done",  32'(load_done),    32'd1);
    check_eq("t2_err2",  32'(load_err),     32'd0);
    check_eq("t2_hold2", 32'(cpu_hold),     32'd0);
    check_eq("t2_words", 32'(words_loaded), 32'd1);
    check_log("t2", 1, 32'hDEADBEEF, 32'd0);

    // Test 3a: same image as test 1, rx_valid toggling every other cycle
    do_reset();
    clear_log();
    send_frame(32'd2, 32'h24080005, 32'h0000000C, 1'b1);
    // The gap after the last byte consumed one cycle; the frame is complete.
    check_eq("t3_hold", 32'(cpu_hold),     32'd0);
    check_eq("t3_done", 32'(load_done),    32'd1);
    check_eq("t3_rdy",  32'(rx_ready),     32'd0);
    check_eq("t3_words", 32'(words_loaded), 32'd2);
    check_log("t3", 2, 32'h24080005, 32'h0000000C);

    // Test 3b: empty image
    do_reset();
    clear_log();
    send_frame(32'd0, 32'd0, 32'd0, 1'b0);
    check_eq("t3n0_hold_edge", 32'(cpu_hold), 32'd1);
    clk_n(1);
    check_eq("t3n0_done",  32'(load_done),    32'd1);
    check_eq("t3n0_hold",  32'(cpu_hold),     32'd0);
    check_eq("t3n0_words", 32'(words_loaded), 32'd0);
    check_log("t3n0", 0, 32'd0, 32'd0);

    // Test 4: reset in the middle of the first data word
    do_reset();
    clear_log();
    send_word(32'd1, 1'b0);
    send_byte(8'h99, 1'b0);
    send_byte(8'h88, 1'b0);
    reset = 1'b1;
    clk_n(1);
    reset = 1'b0;
    check_eq("t4_we",    32'(im_we),        32'd0);
    check_eq("t4_words", 32'(words_loaded), 32'd0);
    check_eq("t4_hold",  32'(cpu_hold),     32'd1);
    send_frame(32'd1, 32'h11223344, 32'd0, 1'b0);
    clk_n(1);
    check_eq("t4_done", 32'(load_done), 32'd1);
    check_log("t4", 1, 32'h11223344, 32'd0);

`ifdef IM_LOADER_CSUM_EN
    // Test 5a: correct checksum 0x24080005 + 0x0000000C = 0x24080011
    do_reset();
    clear_log();
    send_word(32'd2, 1'b0);
    send_word(32'h24080005, 1'b0);
    send_word(32'h0000000C, 1'b0);
    send_word(32'h24080011, 1'b0);
    clk_n(1);
    check_eq("t5ok_done", 32'(load_done), 32'd1);
    check_eq("t5ok_err",  32'(load_err),  32'd0);
    check_eq("t5ok_hold", 32'(cpu_hold),  32'd0);
    check_log("t5ok", 2, 32'h24080005, 32'h0000000C);

    // Test 5b: wrong checksum
    do_reset();
    clear_log();
    send_word(32'd2, 1'b0);
    send_word(32'h24080005, 1'b0);
    send_word(32'h0000000C, 1'b0);
    send_word(32'h24080012, 1'b0);
    clk_n(1);
    check_eq("t5bad_done", 32'(load_done), 32'd0);
    check_eq("t5bad_err",  32'(load_err),  32'd1);
    check_eq("t5bad_hold", 32'(cpu_hold),  32'd1);
    check_log("t5bad", 2, 32'h24080005, 32'h0000000C);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
